// File: rtl/fc_mac_accum_param_1.sv
// Fully-connected layer MAC: two signed products per valid pair, accumulated
// over PAIRS pairs, then shifted and saturated into one output neuron value.
module fc_mac_accum_param_1 #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC       = 8,
  parameter int INNEURON   = 1024,
  parameter int PI         = 4,
  parameter int OUTNEURON  = 10,
  parameter int PO         = 1,
  parameter int RD_LAT     = 3,
  localparam int NOUT      = OUTNEURON / PO,
  localparam int IDX_W     = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] douta,
  input  logic signed [DATA_WIDTH-1:0] doutb,
  input  logic signed [DATA_WIDTH-1:0] wa,
  input  logic signed [DATA_WIDTH-1:0] wb,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         done
);

  localparam int PAIRS  = INNEURON / PI / 2;
  localparam int PCNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAIRS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NOUT - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [RD_LAT-1:0]             dly;
  logic                          vld;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [PCNT_W-1:0]             pcnt;
  logic signed [2*DATA_WIDTH-1:0] pa, pb;
  logic signed [ACC_WIDTH-1:0]   pa_ext, pb_ext, sum, shifted;
  logic signed [DATA_WIDTH-1:0]  sat_val;
  logic                          wrap;
  logic [IDX_W-1:0]              idx_inc, emit_idx;

  assign vld     = dly[RD_LAT-1];
  assign pa      = douta * wa;
  assign pb      = doutb * wb;
  assign pa_ext  = ACC_WIDTH'(pa);
  assign pb_ext  = ACC_WIDTH'(pb);
  assign sum     = acc + pa_ext + pb_ext;
  assign shifted = sum >>> FRAC;
  assign wrap    = vld && (pcnt == PCNT_LAST);
  assign idx_inc = (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
  // A pulse leaving this cycle bumps out_idx, so a back-to-back neuron takes the next index.
  assign emit_idx = out_valid ? idx_inc : out_idx;

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly       <= '0;
      acc       <= '0;
      pcnt      <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      dly       <= RD_LAT'({dly, enable});
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (out_valid) out_idx <= idx_inc;
      if (vld) begin
        if (wrap) begin
          acc       <= '0;
          pcnt      <= '0;
          out_data  <= sat_val;
          out_valid <= 1'b1;
          done      <= (emit_idx == IDX_LAST);
        end else begin
          acc  <= sum;
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_accum_param_1.sv
// Bench for fc_mac_accum_param_1: directed and random pair streams compared
// cycle by cycle against a behavioural neuron-sum model, at FRAC=0 and FRAC=8.
module tb_fc_mac_accum_param_1;

  localparam int N = 512;

  logic clk = 1'b0;
  logic reset, enable;
  logic signed [15:0] douta, doutb, wa, wb;
  logic signed [15:0] out_data0, out_data8;
  logic out_valid0, out_valid8, done0, done8;
  logic [0:0] out_idx0, out_idx8;

  int en_a[N], rst_a[N], da_a[N], db_a[N], wa_a[N], wb_a[N];
  int n_checks = 0, n_pass = 0;
  int ptr = 0, last_t = 0;

  always #5 clk = ~clk;

  fc_mac_accum_param_1 #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC(0), .INNEURON(8), .PI(1),
    .OUTNEURON(2), .PO(1), .RD_LAT(3)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .douta(douta), .doutb(doutb), .wa(wa), .wb(wb),
    .out_data(out_data0), .out_valid(out_valid0), .out_idx(out_idx0), .done(done0));

  fc_mac_accum_param_1 #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC(8), .INNEURON(8), .PI(1),
    .OUTNEURON(2), .PO(1), .RD_LAT(3)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .douta(douta), .doutb(doutb), .wa(wa), .wb(wb),
    .out_data(out_data8), .out_valid(out_valid8), .out_idx(out_idx8), .done(done8));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp, $time);
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Enable at cycle k carries the data that shows up RD_LAT cycles later.
  task automatic add_pair(input int k, input int a, input int x, input int b, input int y);
    en_a[k] = 1;
    da_a[k+3] = a; wa_a[k+3] = x; db_a[k+3] = b; wb_a[k+3] = y;
  endtask

  task automatic add_reset();
    rst_a[ptr] = 1;
    ptr += 2;
  endtask

  // Reference: a neuron is the plain sum of PAIRS=4 surviving pairs' products.
  longint macc, last0, last8;
  int mcnt, nemit;
  bit pulse;

  task automatic model_edge(input int t);
    bit ok;
    longint s;
    if (rst_a[t] != 0) begin
      macc = 0; mcnt = 0; nemit = 0; pulse = 0; last0 = 0; last8 = 0;
      return;
    end
    pulse = 0;
    ok = (t >= 3) && (en_a[t-3] != 0);
    if (ok) for (int j = t - 3; j < t; j++) if (rst_a[j] != 0) ok = 0;
    if (!ok) return;
    s = macc + longint'(da_a[t]) * wa_a[t] + longint'(db_a[t]) * wb_a[t];
    mcnt++;
    if (mcnt == 4) begin
      mcnt = 0; macc = 0; pulse = 1; nemit++;
      last0 = sat16(s);
      last8 = sat16(s >>> 8);
    end else begin
      macc = s;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; douta = '0; doutb = '0; wa = '0; wb = '0;

    // startup reset
    rst_a[0] = 1; rst_a[1] = 1; rst_a[2] = 1;
    ptr = 4;
    // (i,i) on both ports, 4 consecutive enables -> 60
    for (int i = 0; i < 4; i++) add_pair(ptr + i, i + 1, i + 1, i + 1, i + 1);
    ptr += 12; add_reset();
    // 8 enables, data 1 weight 2 -> two neurons of 16
    for (int i = 0; i < 8; i++) add_pair(ptr + i, 1, 2, 1, 2);
    ptr += 16; add_reset();
    // toggling enable
    for (int i = 0; i < 4; i++) add_pair(ptr + 2 * i, i + 1, i + 1, i + 1, i + 1);
    ptr += 14; add_reset();
    // saturation high then low
    for (int i = 0; i < 4; i++) add_pair(ptr + i, 32767, 32767, 32767, 32767);
    ptr += 10;
    for (int i = 0; i < 4; i++) add_pair(ptr + i, -32768, 32767, -32768, 32767);
    ptr += 12; add_reset();
    // reset after two valid pairs, then a clean neuron of 1*1 -> 8
    add_pair(ptr, 5, 5, 5, 5); add_pair(ptr + 1, 5, 5, 5, 5);
    rst_a[ptr + 6] = 1;
    ptr += 8;
    for (int i = 0; i < 4; i++) add_pair(ptr + i, 1, 1, 1, 1);
    ptr += 12; add_reset();
    // reset lands exactly on the wrap edge -> no output
    for (int i = 0; i < 4; i++) add_pair(ptr + i, 1, 1, 1, 1);
    rst_a[ptr + 6] = 1;
    ptr += 10;
    // fractional shift: 0x300 and -0x180
    add_pair(ptr, 16, 48, 0, 0);
    for (int i = 1; i < 4; i++) add_pair(ptr + i, 0, 0, 0, 0);
    ptr += 12;
    add_pair(ptr, -16, 24, 0, 0);
    for (int i = 1; i < 4; i++) add_pair(ptr + i, 0, 0, 0, 0);
    ptr += 12; add_reset();
    // random stream with occasional reset
    for (int k = ptr; k < ptr + 150; k++) begin
      en_a[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rst_a[k] = ($urandom_range(0, 59) == 0) ? 1 : 0;
      da_a[k+3] = int'($urandom_range(0, 65535)) - 32768;
      wa_a[k+3] = int'($urandom_range(0, 65535)) - 32768;
      db_a[k+3] = int'($urandom_range(0, 65535)) - 32768;
      wb_a[k+3] = int'($urandom_range(0, 65535)) - 32768;
    end
    last_t = ptr + 160;

    macc = 0; last0 = 0; last8 = 0; mcnt = 0; nemit = 0; pulse = 0;
    @(negedge clk);
    for (int t = 0; t < last_t; t++) begin
      reset  = rst_a[t] != 0;
      enable = en_a[t] != 0;
      douta  = 16'(da_a[t]); wa = 16'(wa_a[t]);
      doutb  = 16'(db_a[t]); wb = 16'(wb_a[t]);
      @(posedge clk);
      #1;
      model_edge(t);
      chk("out_valid", longint'(out_valid0), longint'(pulse));
      chk("out_data", longint'(out_data0), last0);
      chk("out_idx", longint'(out_idx0), pulse ? longint'((nemit - 1) % 2) : longint'(nemit % 2));
      chk("done", longint'(done0), longint'(pulse && ((nemit - 1) % 2 == 1)));
      chk("out_valid_frac8", longint'(out_valid8), longint'(pulse));
      chk("out_data_frac8", longint'(out_data8), last8);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_mac_accum_param_1.md
FC_MAC_ACCUM_PARAM_1 -- requirements
Module: fc_mac_accum_param_1

Interface
REQ-001 Parameter DATA_WIDTH, 16, signed width of neuron data, weights and result.
REQ-002 Parameter ACC_WIDTH, 40, signed accumulator width.
REQ-003 Parameter FRAC, 8, fractional bits removed from the accumulator before output.
REQ-004 Parameter INNEURON, 1024, input neurons per output neuron.
REQ-005 Parameter PI, 4, input parallelism; pairs per neuron PAIRS = INNEURON/PI/2, which shall be at least 1.
REQ-006 Parameter OUTNEURON, 10, output neuron count.
REQ-007 Parameter PO, 1, output parallelism; neurons per pass NOUT = OUTNEURON/PO.
REQ-008 Parameter RD_LAT, 3, cycles from enable to aligned RAM data (2 address-generator stages + 1 RAM read).
REQ-009 clk, input, 1, single clock; all state updates on rising edge.
REQ-010 reset, input, 1, synchronous active-high reset.
REQ-011 enable, input, 1, the same enable that steps the upstream address generator.
REQ-012 douta, input, DATA_WIDTH, signed neuron read at addra (even address).
REQ-013 doutb, input, DATA_WIDTH, signed neuron read at addrb (odd address).
REQ-014 wa, input, DATA_WIDTH, signed weight paired with douta, aligned with it.
REQ-015 wb, input, DATA_WIDTH, signed weight paired with doutb, aligned with it.
REQ-016 out_data, output, DATA_WIDTH, saturated result of one output neuron.
REQ-017 out_valid, output, 1, one-cycle pulse marking out_data valid.
REQ-018 out_idx, output, clog2(NOUT), index of the neuron in out_data.
REQ-019 done, output, 1, one-cycle pulse, coincident with out_valid, for the neuron at index NOUT-1.

Function
REQ-020 Delay enable through an RD_LAT-stage shift register; its last stage is vld, marking douta/doutb/wa/wb as a valid pair.
REQ-021 The shift register advances every cycle regardless of enable; no back-pressure exists.
REQ-022 On vld, compute pa = douta*wa and pb = doutb*wb as full 2*DATA_WIDTH signed products, sign-extend to ACC_WIDTH, and add both to the accumulator.
REQ-023 Pair counter pcnt counts vld cycles 0..PAIRS-1; on vld with pcnt = PAIRS-1, it wraps to 0.
REQ-024 On the wrap cycle, the final sum S = acc + pa + pb.
REQ-025 On the wrap cycle, acc shall be loaded with 0, so the next neuron starts from zero with no bubble.
REQ-026 One cycle after the wrap cycle, out_data = saturate(S >>> FRAC) to the signed DATA_WIDTH range, and out_valid = 1.
REQ-027 The shift in REQ-026 is arithmetic; saturation clamps to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
REQ-028 out_idx holds the index of the emitted neuron, then increments after each out_valid, wrapping NOUT-1 -> 0.
REQ-029 done = 1 in the same cycle as out_valid when out_idx = NOUT-1.
REQ-030 Cycles with vld = 0 hold acc, pcnt and out_idx unchanged.
REQ-031 out_data holds its last value between pulses.
REQ-032 With PAIRS = 1, every vld cycle is a wrap cycle and produces one output.
REQ-033 Accumulator overflow within ACC_WIDTH wraps (two's complement); only the output stage saturates.

Reset
REQ-034 While reset is high at a clock edge, clear the delay line, acc, pcnt, out_idx, out_data, out_valid and done to 0.
REQ-035 Reset mid-neuron discards the partial sum and any in-flight delayed enables; the first vld after reset counts as pcnt = 0.
REQ-036 Reset overrides a simultaneous wrap cycle, so no out_valid appears after that edge.

Verification
REQ-037 Bench parameters: INNEURON=8, PI=1 (PAIRS=4), FRAC=0, OUTNEURON=2, PO=1, RD_LAT=3.
REQ-038 Pairs (1,1)(2,2)(3,3)(4,4) for data·weight on both ports, enable high 4 cycles -> out_data=60, out_valid one pulse 4 cycles after the last enable cycle (3 cycles delay + 1 cycle register), out_idx=0, done=0.
REQ-039 Enable held high 8 cycles, all data=1 and weights=2 -> two pulses each 16; the second has out_idx=1 and done=1; out_idx then returns to 0.
REQ-040 Enable toggling 1,0,1,0,... with the REQ-038 data -> same result 60, and no output before the 4th vld.
REQ-041 All data=32767, weights=32767, FRAC=0 -> out_data=32767 (saturated); with -32768·32767 -> out_data=-32768.
REQ-042 Reset asserted after 2 vld cycles, then 4 fresh vld pairs of 1·1 -> out_data=8; no output from the aborted partial sum.
REQ-043 FRAC=8, products summing to 0x300 -> out_data=3; sum -0x180 -> out_data=-2 (arithmetic shift).
